// File: rtl/hazard_if.sv
// Hazard unit handshake bundle: ID/EXE-side request signals and the
// stall/flush/forward-select responses from the scoreboard.
interface hazard_if #(
   parameter int unsigned RA_W  = 5,
   parameter int unsigned FWD_W = 2
);
   logic              id_valid;
   logic [RA_W-1:0]   id_rs;
   logic [RA_W-1:0]   id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic              id_wr_en;
   logic [RA_W-1:0]   id_wr_addr;
   logic              id_is_load;
   logic              ex_branch;
   logic              stall;
   logic              flush;
   logic [FWD_W-1:0]  exe_fwd_a;
   logic [FWD_W-1:0]  exe_fwd_b;

   // Pipeline control side: presents the ID instruction and the EXE branch outcome
   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wr_en, id_wr_addr, id_is_load, ex_branch,
      input  stall, flush, exe_fwd_a, exe_fwd_b
   );

   // Hazard unit side
   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wr_en, id_wr_addr, id_is_load, ex_branch,
      output stall, flush, exe_fwd_a, exe_fwd_b
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit with a private shift-register record of in-flight
// register writes. Slot j describes the producer j+1 stages ahead of ID
// (slot 0 is in EXE). Drives combinational stall/flush and registered EXE
// operand-forward selects. Optional macro HAZ_PERF_CNT_EN adds free-running
// stall/flush event counters.
module hazard_scoreboard #(
   parameter int unsigned RA_W      = 5,
   parameter int unsigned FWD_DEPTH = 2,
   parameter int unsigned LOAD_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   hazard_if.slave     hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int unsigned FWD_W = $clog2(FWD_DEPTH + 1);

   typedef struct packed {
      logic            v;
      logic            ld;
      logic [RA_W-1:0] addr;
   } slot_t;

   slot_t            slot_q [FWD_DEPTH];
   slot_t            slot_d [FWD_DEPTH];
   logic [FWD_W-1:0] fwd_a_q, fwd_a_d;
   logic [FWD_W-1:0] fwd_b_q, fwd_b_d;

   logic [FWD_W-1:0] code_a_c, code_b_c;
   logic             lu_a_c, lu_b_c;
   logic             stall_c, flush_c, push_c;

   // Youngest-match search for each source; iterating oldest-first lets the
   // youngest hit overwrite. A load too young to forward flags load-use.
   always_comb begin
      code_a_c = '0;
      code_b_c = '0;
      lu_a_c   = 1'b0;
      lu_b_c   = 1'b0;
      for (int j = int'(FWD_DEPTH) - 1; j >= 0; j--) begin
         if (slot_q[j].v && hz.id_use_rs && (hz.id_rs != '0) &&
             (slot_q[j].addr == hz.id_rs)) begin
            code_a_c = FWD_W'(j + 1);
            lu_a_c   = slot_q[j].ld && (j < int'(LOAD_LAT));
         end
         if (slot_q[j].v && hz.id_use_rt && (hz.id_rt != '0) &&
             (slot_q[j].addr == hz.id_rt)) begin
            code_b_c = FWD_W'(j + 1);
            lu_b_c   = slot_q[j].ld && (j < int'(LOAD_LAT));
         end
      end
   end

   // Pipeline control: a taken branch overrides stall; both are quiet in reset.
   always_comb begin
      flush_c = hz.ex_branch & ~rst;
      stall_c = ~rst & hz.id_valid & ~hz.ex_branch & (lu_a_c | lu_b_c);
      push_c  = hz.id_valid & hz.id_wr_en & (hz.id_wr_addr != '0) &
                ~stall_c & ~flush_c;
   end

   // Next scoreboard contents and EXE selects; a stalled or squashed ID
   // instruction becomes a bubble in EXE.
   always_comb begin
      slot_d[0]      = '0;
      if (push_c) begin
         slot_d[0].v    = 1'b1;
         slot_d[0].ld   = hz.id_is_load;
         slot_d[0].addr = hz.id_wr_addr;
      end
      for (int j = 1; j < int'(FWD_DEPTH); j++) begin
         slot_d[j] = slot_q[j-1];
      end
      fwd_a_d = '0;
      fwd_b_d = '0;
      if (hz.id_valid && !stall_c && !flush_c) begin
         fwd_a_d = code_a_c;
         fwd_b_d = code_b_c;
      end
   end

   // Scoreboard shift register and registered forward selects
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < int'(FWD_DEPTH); j++) begin
            slot_q[j] <= '0;
         end
         fwd_a_q <= '0;
         fwd_b_q <= '0;
      end else begin
         for (int j = 0; j < int'(FWD_DEPTH); j++) begin
            slot_q[j] <= slot_d[j];
         end
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign hz.stall     = stall_c;
   assign hz.flush     = flush_c;
   assign hz.exe_fwd_a = fwd_a_q;
   assign hz.exe_fwd_b = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Event counters, one count per cycle the output is asserted; wrap freely
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_q + 32'(stall_c);
         flush_cnt_q <= flush_cnt_q + 32'(flush_c);
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
